// File: rtl/io_bus_pkg.sv
// io_mem bus shared types and constants.
// FSM states, IO address map, default error data.
package io_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } io_state_t;

  localparam logic [27:0] ADDR_SPART_DATA = 28'h8000000;
  localparam logic [27:0] ADDR_SPART_STAT = 28'h8000001;
  localparam logic [27:0] ADDR_DVI_START  = 28'h8000004;
  localparam logic [27:0] ADDR_DISP_ON    = 28'h8000005;
  localparam logic [27:0] ADDR_TICK       = 28'h8000006;

  localparam logic [31:0] ERR_DATA_DFLT = 32'hFFFF_FFFF;

endpackage

// File: rtl/io_timeout_counter.sv
// Saturating phase counter for the io_mem initiator.
// clk, rst (async low), clr, en in; timeout out.
module io_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  localparam int W = (TIMEOUT_CYCLES > 2) ?
                     $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign timeout = (count == LAST);

endmodule

// File: rtl/io_bus_initiator.sv
// CPU-side initiator for the io_mem valid/ready bus.
// cpu_* request/response, io_mem_* bus; all outputs registered.
module io_bus_initiator
  import io_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [27:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_busy,
  output logic        cpu_err,
  output logic [31:0] io_mem_data_wr,
  input  logic [31:0] io_mem_data_rd,
  output logic [27:0] io_mem_data_addr,
  output logic        io_mem_rw_data,
  output logic        io_mem_valid_data,
  input  logic        io_mem_ready_data
);

  io_state_t   state_q, state_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [27:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rw_q, rw_d;
  logic        timeout;
  logic        cnt_clr;
  logic        cnt_en;

  // Counter restarts whenever the FSM changes state.
  assign cnt_clr = (state_d != state_q) ||
                   (state_q == ST_IDLE);
  assign cnt_en  = (state_q != ST_IDLE);

  io_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .timeout(timeout)
  );

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          rw_d    = cpu_we;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (io_mem_ready_data) begin
          if (!rw_q) rdata_d = io_mem_data_rd;
          done_d  = 1'b1;
          state_d = ST_ACK;
        end else if (timeout) begin
          if (!rw_q) rdata_d = ERR_DATA;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        // Valid stays up until the responder drops ready.
        if (!io_mem_ready_data) begin
          state_d = ST_IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) begin
      valid_d = 1'b0;
      busy_d  = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      rw_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
    end
  end

  assign cpu_rdata         = rdata_q;
  assign cpu_done          = done_q;
  assign cpu_busy          = busy_q;
  assign cpu_err           = err_q;
  assign io_mem_data_wr    = wdata_q;
  assign io_mem_data_addr  = addr_q;
  assign io_mem_rw_data    = rw_q;
  assign io_mem_valid_data = valid_q;

endmodule

// File: tb/tb_io_bus_initiator.sv
// Self-checking bench for io_bus_initiator.
// Model responder plus per-transaction timing model.
module tb_io_bus_initiator;
  import io_bus_pkg::*;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [27:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_busy;
  logic        cpu_err;
  logic [31:0] io_mem_data_wr;
  logic [31:0] io_mem_data_rd;
  logic [27:0] io_mem_data_addr;
  logic        io_mem_rw_data;
  logic        io_mem_valid_data;
  logic        io_mem_ready_data;

  int vectors = 0;
  int errors  = 0;

  // responder: 0 normal, 1 ready tied low, 2 ready stuck high
  int          rsp_mode = 1;
  int          rsp_wait = 0;
  logic [31:0] rsp_rdata = '0;
  logic [31:0] rsp_mem = '0;
  logic        ready = 1'b0;
  int          hi = 0;
  int          wcnt = 0;
  bit          served = 0;
  logic [31:0] model_rdata = '0;

  always #5 clk = ~clk;

  assign io_mem_ready_data = ready;
  assign io_mem_data_rd    = rsp_rdata;

  io_bus_initiator #(
    .TIMEOUT_CYCLES(T),
    .ERR_DATA      (32'hFFFF_FFFF)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cpu_req          (cpu_req),
    .cpu_we           (cpu_we),
    .cpu_addr         (cpu_addr),
    .cpu_wdata        (cpu_wdata),
    .cpu_rdata        (cpu_rdata),
    .cpu_done         (cpu_done),
    .cpu_busy         (cpu_busy),
    .cpu_err          (cpu_err),
    .io_mem_data_wr   (io_mem_data_wr),
    .io_mem_data_rd   (io_mem_data_rd),
    .io_mem_data_addr (io_mem_data_addr),
    .io_mem_rw_data   (io_mem_rw_data),
    .io_mem_valid_data(io_mem_valid_data),
    .io_mem_ready_data(io_mem_ready_data)
  );

  always @(posedge clk) begin
    if (!rst) begin
      hi <= 0;
    end else if (io_mem_valid_data && ready) begin
      if (io_mem_rw_data && hi == 0) rsp_mem <= io_mem_data_wr;
      hi <= hi + 1;
    end else if (!io_mem_valid_data) begin
      hi <= 0;
    end
  end

  // Ready rises after rsp_wait cycles, stays up for two
  // sampled edges, then drops while valid is still high.
  always @(negedge clk) begin
    if (!rst || rsp_mode == 1) begin
      ready = 1'b0; served = 0; wcnt = 0;
    end else if (!io_mem_valid_data) begin
      if (!ready) begin served = 0; wcnt = 0; end
    end else if (!ready && !served) begin
      if (wcnt >= rsp_wait) ready = 1'b1;
      else wcnt++;
    end else if (ready && rsp_mode == 0 && hi >= 2) begin
      ready = 1'b0; served = 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_txn(input string tag,
                         input logic we,
                         input logic [27:0] addr,
                         input logic [31:0] wd,
                         input int w,
                         input int mode);
    int done_k = -1, err_k = -1, idle_k = -1;
    int ndone = 0, nerr = 0, vhi = 1;
    int e_done, e_err, e_idle, e_nerr;
    bit unstable = 0;
    logic [31:0] rd_at_done = 'x;
    logic [31:0] e_rd;
    rsp_mode = mode; rsp_wait = w;
    cpu_req = 1'b1; cpu_we = we;
    cpu_addr = addr; cpu_wdata = wd;
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_addr = ~addr; cpu_wdata = ~wd;
    chk({tag, " valid@N"}, 32'(io_mem_valid_data), 32'd1);
    chk({tag, " busy@N"}, 32'(cpu_busy), 32'd1);
    for (int k = 1; k <= 40 && idle_k < 0; k++) begin
      @(posedge clk); #1;
      if (cpu_done) begin
        ndone++;
        if (done_k < 0) begin done_k = k; rd_at_done = cpu_rdata; end
      end
      if (cpu_err) begin nerr++; err_k = k; end
      if (io_mem_valid_data) begin
        vhi++;
        if (io_mem_data_addr !== addr || io_mem_rw_data !== we ||
            io_mem_data_wr !== wd) unstable = 1;
      end
      if (!cpu_busy) idle_k = k;
    end
    e_done = w + 1; e_err = -1; e_idle = w + 3; e_nerr = 0;
    e_rd = we ? model_rdata : rsp_rdata;
    if (mode == 1) begin
      e_done = T; e_err = T; e_idle = T; e_nerr = 1;
      e_rd = we ? model_rdata : 32'hFFFF_FFFF;
    end else if (mode == 2) begin
      e_err = w + 1 + T; e_idle = w + 1 + T; e_nerr = 1;
    end
    model_rdata = e_rd;
    chk({tag, " done cycle"}, 32'(done_k), 32'(e_done));
    chk({tag, " done count"}, 32'(ndone), 32'd1);
    chk({tag, " err count"}, 32'(nerr), 32'(e_nerr));
    chk({tag, " err cycle"}, 32'(err_k), 32'(e_err));
    chk({tag, " idle cycle"}, 32'(idle_k), 32'(e_idle));
    chk({tag, " valid cycles"}, 32'(vhi), 32'(e_idle));
    chk({tag, " fields stable"}, 32'(unstable), 32'd0);
    chk({tag, " rdata"}, rd_at_done, e_rd);
    chk({tag, " idle valid"}, 32'(io_mem_valid_data), 32'd0);
    chk({tag, " idle addr"}, 32'(io_mem_data_addr), 32'd0);
    chk({tag, " idle wdata"}, io_mem_data_wr, 32'd0);
    if (we && mode == 0) chk({tag, " rsp reg"}, rsp_mem, wd);
    if (mode == 2) begin
      rsp_mode = 1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int nd, d1, d2, acc2, busy3;
    logic pv;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", 32'(io_mem_valid_data), 32'd0);
    chk("rst busy", 32'(cpu_busy), 32'd0);
    chk("rst done", 32'(cpu_done), 32'd0);
    chk("rst err", 32'(cpu_err), 32'd0);
    chk("rst rdata", cpu_rdata, 32'd0);
    chk("rst addr", 32'(io_mem_data_addr), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    run_txn("store dvi", 1'b1, ADDR_DVI_START, 32'h0123_4567, 0, 0);
    rsp_rdata = 32'h0000_00A5;
    run_txn("load tick", 1'b0, ADDR_TICK, 32'h0, 0, 0);
    run_txn("timeout", 1'b0, ADDR_SPART_STAT, 32'h0, 0, 1);
    rsp_rdata = 32'h5A5A_1234;
    run_txn("stuck rdy", 1'b0, ADDR_SPART_DATA, 32'h0, 0, 2);
    run_txn("wr timeout", 1'b1, ADDR_SPART_DATA, 32'h77, 0, 1);

    // back-to-back loads with cpu_req held high
    rsp_mode = 0; rsp_wait = 0; rsp_rdata = $urandom;
    cpu_we = 1'b0; cpu_addr = ADDR_DISP_ON; cpu_req = 1'b1;
    @(posedge clk); #1;
    nd = 0; d1 = -1; d2 = -1; acc2 = -1; busy3 = -1;
    pv = io_mem_valid_data;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (cpu_done) begin
        nd++;
        if (d1 < 0) d1 = k; else if (d2 < 0) d2 = k;
      end
      if (!pv && io_mem_valid_data && acc2 < 0) acc2 = k;
      pv = io_mem_valid_data;
      if (k == 3) busy3 = 32'(cpu_busy);
      if (k == 6) cpu_req = 1'b0;
    end
    model_rdata = rsp_rdata;
    chk("b2b done count", 32'(nd), 32'd2);
    chk("b2b first done", 32'(d1), 32'd1);
    chk("b2b second done", 32'(d2), 32'd5);
    chk("b2b second accept", 32'(acc2), 32'd4);
    chk("b2b busy gap", 32'(busy3), 32'd0);
    chk("b2b rdata", cpu_rdata, model_rdata);

    // asynchronous reset during REQ
    rsp_mode = 1;
    cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = ADDR_TICK; cpu_wdata = 32'hCAFE_0001;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0; #1;
    chk("arst valid", 32'(io_mem_valid_data), 32'd0);
    chk("arst busy", 32'(cpu_busy), 32'd0);
    chk("arst done", 32'(cpu_done), 32'd0);
    chk("arst err", 32'(cpu_err), 32'd0);
    chk("arst rdata", cpu_rdata, 32'd0);
    model_rdata = '0;
    @(negedge clk); rst = 1'b1;
    run_txn("post rst", 1'b1, ADDR_DVI_START, 32'hBEEF_0042, 1, 0);

    for (int i = 0; i < 6; i++) begin
      rsp_rdata = $urandom;
      run_txn($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
              ADDR_SPART_DATA + 28'($urandom_range(0, 6)),
              $urandom, int'($urandom_range(0, 3)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/io_bus_initiator.md
# io_bus_initiator

Initiator side of the io_mem valid/ready memory-mapped IO bus. Sits between the CPU memory stage (uncached IO accesses, address space 28'h8000000 and up) and the IO address map block. Converts a single-cycle CPU load/store request into a full io_mem handshake, returns read data, stalls the pipeline while busy, and aborts with an error if the responder never answers.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1024: cycles an io_mem phase may wait on ready before abort; must be ≥ 2.
- ERR_DATA, 32'hFFFF_FFFF: read data returned on timeout.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- cpu_req  in  1  request strobe; sampled only in IDLE
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  28  word address
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data; held until next accepted request
- cpu_done  out  1  one-cycle pulse: access complete, cpu_rdata valid
- cpu_busy  out  1  transaction in flight; CPU stalls while high
- cpu_err  out  1  one-cycle pulse, coincident with cpu_done, on timeout
- io_mem_data_wr  out  32  store data to responder
- io_mem_data_rd  in  32  responder read data, valid while ready = 1
- io_mem_data_addr  out  28  address
- io_mem_rw_data  out  1  1 = write, 0 = read
- io_mem_valid_data  out  1  request valid
- io_mem_ready_data  in  1  responder ready

## Operation
- Responder contract: with valid high, responder raises ready; valid held high while ready is high makes the responder drop ready. Responder leaves ready high if valid drops first, so the initiator must keep valid until ready returns to 0.
- States: IDLE, REQ, ACK.
- IDLE: cpu_busy = 0, valid = 0. cpu_req = 1 → latch we/addr/wdata into io_mem_* registers, valid ← 1, busy ← 1, → REQ.
- REQ: valid = 1. ready = 1 → cpu_rdata ← io_mem_data_rd (reads only; writes leave cpu_rdata unchanged), cpu_done pulse, → ACK. Timeout → cpu_rdata ← ERR_DATA (reads only), cpu_done + cpu_err pulse, valid ← 0, → IDLE.
- ACK: valid = 1 held. ready = 0 → valid ← 0, busy ← 0, → IDLE. Timeout → valid ← 0, busy ← 0, cpu_err pulse (no second cpu_done), → IDLE.
- Timeout counter clears on every state entry, increments each cycle in REQ/ACK, saturates; timeout = count reaches TIMEOUT_CYCLES-1.
- cpu_req while busy is ignored (not queued).
- io_mem_* address/data/rw stay stable for the whole transaction; cleared to 0 on return to IDLE.

## Timing
- Reset values: all outputs 0, cpu_rdata 0, state IDLE, counter 0. Reset asserted mid-transaction drops valid immediately (asynchronous); no done/err pulse.
- cpu_req sampled at edge N → valid high from N; cpu_busy high from N.
- Zero-wait responder (ready at N+1): cpu_done/cpu_rdata at edge N+1; responder drops ready at N+2; ACK sees ready = 0 at N+3; valid low, busy low after N+3. Next request accepted at edge N+4 earliest.
- Minimum transaction: 4 cycles request-to-next-accept.
- Outputs fully registered; no combinational path from io_mem_ready_data to any output.

## Structure
- Package io_bus_pkg: state encoding (IDLE/REQ/ACK), IO address constants (SPART 28'h8000000/1, DVI start 28'h8000004, display-on 28'h8000005, tick 28'h8000006), default ERR_DATA.
- One sub-module natural: io_timeout_counter (clear, enable, saturating count, timeout flag), parameterised by TIMEOUT_CYCLES.

## Test plan
- Store 32'h0123_4567 to 28'h8000004 with model responder → valid held 3 cycles, write fields stable, cpu_done at N+1, busy low after N+3, responder register = 28'h0123_4567.
- Load 28'h8000006 with responder returning 32'h0000_00A5 → cpu_rdata = 32'h0000_00A5 at cpu_done, cpu_err = 0.
- Ready tied 0, TIMEOUT_CYCLES = 8 → cpu_done + cpu_err pulse after 8 REQ cycles, cpu_rdata = 32'hFFFF_FFFF, valid low.
- Ready stuck 1 after first assert → done at capture, err pulse from ACK after TIMEOUT_CYCLES, busy clears.
- Back-to-back loads of 28'h8000005 with cpu_req held high → second request accepted only after busy low; exactly two done pulses; extra cpu_req during busy ignored.
- rst driven 0 during REQ → valid, busy, done all 0 asynchronously; after release a new store completes normally.
